eth_tx_sched: RTL
=================

// Module: eth_tx_sched
// PURPOSE
//  Round-robin scheduler sharing the single eth_tx pipe between REQ_N packet sources.
//  Picks a winner, launches the frame (early valid + UDP length) and tracks it through
//  head/data/foot. Drives the external data-mux select and enforces a minimum
//  inter-frame gap. Sits between the application request ports and eth_tx.
// PARAMETERS
//  REQ_N      4   number of requesters (>=2)
//  SEL_W      $clog2(REQ_N)  width of the select index
//  PKT_LEN_W  16  UDP payload length width
//  IFG_CYC    3   idle cycles enforced after tx_idle_i returns high
//  IFG_W      $clog2(IFG_CYC+1)  width of the gap counter
//  WDOG_CYC   1024  watchdog limit in DATA, used only with ETH_TX_SCHED_WDOG_EN
// PORTS
//  clk          in   1                clock
//  nreset       in   1                async active-low reset
//  req_v_i      in   REQ_N            per-source packet request, held until its last beat
//  req_len_i    in   REQ_N*PKT_LEN_W  per-source UDP payload length; slice k = [k*PKT_LEN_W+:PKT_LEN_W]
//  req_last_i   in   REQ_N            per-source last data beat
//  grant_o      out  REQ_N            one-hot; the selected source may stream data
//  sel_o        out  SEL_W            index of the selected source, for the data/len/last mux
//  tx_early_v_o out  1                eth_tx app_early_v
//  tx_pkt_len_o out  PKT_LEN_W        eth_tx app_pkt_len; latched on grant
//  tx_cancel_o  out  1                eth_tx app_cancel; 1-cycle pulse
//  tx_ready_i   in   1                eth_tx app_ready_v (pipe is in its data state)
//  tx_idle_i    in   1                eth_tx phy_idle
//  busy_o       out  1                state != IDLE, or gap counter != 0
//  err_o        out  1                1-cycle pulse on any cancel
// BEHAVIOUR
//  Reset (async, nreset=0):
//   - state IDLE; all outputs 0.
//   - rr pointer 0; gap counter 0; watchdog counter 0.
//  States: IDLE -> LAUNCH -> HEAD -> DATA -> FOOT -> IDLE.
//  IDLE:
//   - Arbitrate only when req_v_i != 0 and gap counter == 0.
//   - Winner is the first asserted req_v_i at index >= pointer, wrapping modulo REQ_N.
//   - Next edge: sel_o and tx_pkt_len_o latch the winner and its length; go to LAUNCH.
//  LAUNCH:
//   - tx_early_v_o = 1 for exactly this one cycle; go to HEAD.
//  HEAD:
//   - Wait for tx_ready_i = 1, then go to DATA.
//   - No timeout in HEAD.
//  DATA:
//   - grant_o[sel_o] = tx_ready_i. All other grant bits are 0 in every state.
//   - Beat k is consumed when grant_o[sel_o] = 1.
//   - On req_last_i[sel_o] & grant_o[sel_o]: go to FOOT.
//  FOOT:
//   - Wait for tx_idle_i = 1.
//   - Then: load gap counter with IFG_CYC; pointer <= (sel_o+1) mod REQ_N; go to IDLE.
//  Gap counter:
//   - Decrements by 1 per cycle while nonzero; never underflows.
//   - IFG_CYC = 0 allows back-to-back arbitration.
//  Abort:
//   - Trigger: req_v_i[sel_o] = 0 in LAUNCH, HEAD or DATA, before the last beat.
//   - Same cycle: tx_cancel_o = 1 and err_o = 1.
//   - Next edge: IDLE; pointer <= sel_o+1; gap counter <= IFG_CYC.
//  Simultaneous events:
//   - Last beat and req_v drop in the same DATA cycle count as a normal end, not an abort.
//   - New requests arriving during any non-IDLE state wait; they never preempt.
//   - tx_pkt_len_o is stable from LAUNCH until return to IDLE.
//  Arithmetic:
//   - Pointer wrap is explicit compare to REQ_N-1.
//   - Non-power-of-2 REQ_N is supported; indices >= REQ_N are never selected.
// CONFIGURATION
//  ETH_TX_SCHED_WDOG_EN defined:
//   - Counter clears on entry to DATA and increments each DATA cycle.
//   - On reaching WDOG_CYC: same action as abort (tx_cancel_o and err_o pulse, IDLE, pointer advance).
//  ETH_TX_SCHED_WDOG_EN undefined:
//   - No counter is built; DATA waits indefinitely.
// TESTING
//  1 Single source: REQ_N=4, req_v_i=4'b0100, len=0x0040.
//    -> sel_o=2, tx_pkt_len_o=0x0040, tx_early_v_o 1 cycle after grant edge,
//       grant_o=4'b0100 while tx_ready_i=1.
//  2 Round-robin fairness: all four requesting continuously.
//    -> grant order 0,1,2,3,0, with >=IFG_CYC idle cycles between frames.
//  3 Wrap and skip: pointer=3, req_v_i=4'b0011.
//    -> sel_o=0, then sel_o=1.
//  4 Abort: drop req_v_i[sel] mid-DATA.
//    -> tx_cancel_o=1 and err_o=1 for exactly 1 cycle; IDLE next cycle; busy_o held during gap.
//  5 Async reset in DATA (nreset=0 asynchronously, not on a clock edge).
//    -> grant_o=0, tx_early_v_o=0, sel_o=0 immediately; first arbitration after release starts at index 0.
//  6 With ETH_TX_SCHED_WDOG_EN, WDOG_CYC=16, req_last never asserted.
//    -> tx_cancel_o pulses 16 cycles after DATA entry; no pulse when the macro is undefined.

Source files
------------

// File: rtl/eth_tx_sched.sv
// Round-robin scheduler sharing one eth_tx pipe between REQ_N packet sources.
// Optional DATA-phase watchdog is built only when ETH_TX_SCHED_WDOG_EN is defined.
module eth_tx_sched #(
    parameter int REQ_N     = 4,
    parameter int SEL_W     = (REQ_N > 1) ? $clog2(REQ_N) : 1,
    parameter int PKT_LEN_W = 16,
    parameter int IFG_CYC   = 3,
    parameter int IFG_W     = (IFG_CYC > 0) ? $clog2(IFG_CYC + 1) : 1,
    parameter int WDOG_CYC  = 1024
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [REQ_N-1:0]           req_v_i,
    input  logic [REQ_N*PKT_LEN_W-1:0] req_len_i,
    input  logic [REQ_N-1:0]           req_last_i,
    output logic [REQ_N-1:0]           grant_o,
    output logic [SEL_W-1:0]           sel_o,
    output logic                       tx_early_v_o,
    output logic [PKT_LEN_W-1:0]       tx_pkt_len_o,
    output logic                       tx_cancel_o,
    input  logic                       tx_ready_i,
    input  logic                       tx_idle_i,
    output logic                       busy_o,
    output logic                       err_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_HEAD   = 3'd2,
        ST_DATA   = 3'd3,
        ST_FOOT   = 3'd4
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [SEL_W-1:0]       sel_r;
    logic [SEL_W-1:0]       ptr_r;
    logic [SEL_W-1:0]       next_ptr_s;
    logic [PKT_LEN_W-1:0]   len_r;
    logic [IFG_W-1:0]       gap_r;
    logic                   found_hi_s;
    logic [SEL_W-1:0]       win_hi_s;
    logic                   found_lo_s;
    logic [SEL_W-1:0]       win_lo_s;
    logic [SEL_W-1:0]       win_s;
    logic [PKT_LEN_W-1:0]   win_len_s;
    logic                   arb_go_s;
    logic                   req_v_sel_s;
    logic                   req_last_sel_s;
    logic                   last_beat_s;
    logic                   abort_s;
    logic                   wdog_hit_s;
    logic                   cancel_s;
    logic                   early_v_s;
    logic [REQ_N-1:0]       grant_s;
    logic                   frame_end_s;

    // Rotating-priority search: first request at or above the pointer, else the lowest request.
    always_comb begin
        found_hi_s = 1'b0;
        win_hi_s   = '0;
        found_lo_s = 1'b0;
        win_lo_s   = '0;
        for (int j = 0; j < REQ_N; j++) begin
            if (!found_hi_s && req_v_i[j] && (SEL_W'(j) >= ptr_r)) begin
                found_hi_s = 1'b1;
                win_hi_s   = SEL_W'(j);
            end else begin
                found_hi_s = found_hi_s;
            end
            if (!found_lo_s && req_v_i[j]) begin
                found_lo_s = 1'b1;
                win_lo_s   = SEL_W'(j);
            end else begin
                found_lo_s = found_lo_s;
            end
        end
        win_s = found_hi_s ? win_hi_s : win_lo_s;
    end

    // Per-source muxes for the winner length and the selected source's handshake bits.
    always_comb begin
        win_len_s      = '0;
        req_v_sel_s    = 1'b0;
        req_last_sel_s = 1'b0;
        grant_s        = '0;
        for (int j = 0; j < REQ_N; j++) begin
            if (win_s == SEL_W'(j)) begin
                win_len_s = req_len_i[j*PKT_LEN_W +: PKT_LEN_W];
            end else begin
                win_len_s = win_len_s;
            end
            if (sel_r == SEL_W'(j)) begin
                req_v_sel_s    = req_v_i[j];
                req_last_sel_s = req_last_i[j];
                grant_s[j]     = (state_r == ST_DATA) && tx_ready_i;
            end else begin
                grant_s[j] = 1'b0;
            end
        end
    end

    assign arb_go_s    = (state_r == ST_IDLE) && (|req_v_i) && (gap_r == '0);
    assign next_ptr_s  = (sel_r == SEL_W'(REQ_N - 1)) ? '0 : sel_r + SEL_W'(1);
    // A last beat wins over a simultaneous request drop.
    assign last_beat_s = (state_r == ST_DATA) && tx_ready_i && req_last_sel_s;
    assign abort_s     = ((state_r == ST_LAUNCH) || (state_r == ST_HEAD) || (state_r == ST_DATA))
                         && !req_v_sel_s && !last_beat_s;
    assign cancel_s    = abort_s || wdog_hit_s;
    assign frame_end_s = (state_r == ST_FOOT) && tx_idle_i;

`ifdef ETH_TX_SCHED_WDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYC + 1);
    logic [WDOG_W-1:0] wdog_r;

    // Watchdog counts DATA cycles, restarting on each DATA entry.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wdog_r <= '0;
        end else if ((state_r == ST_HEAD) && tx_ready_i) begin
            wdog_r <= '0;
        end else if ((state_r == ST_DATA) && (wdog_r != WDOG_W'(WDOG_CYC))) begin
            wdog_r <= wdog_r + WDOG_W'(1);
        end else begin
            wdog_r <= wdog_r;
        end
    end

    assign wdog_hit_s = (state_r == ST_DATA) && (wdog_r == WDOG_W'(WDOG_CYC)) && !last_beat_s;
`else
    logic unused_wdog_s;
    assign unused_wdog_s = (WDOG_CYC == 0);
    assign wdog_hit_s    = 1'b0;
`endif

    // Frame sequencing state register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_s   = state_r;
        early_v_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (arb_go_s) begin
                    state_s = ST_LAUNCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                early_v_s = 1'b1;
                if (cancel_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (cancel_s) begin
                    state_s = ST_IDLE;
                end else if (tx_ready_i) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_HEAD;
                end
            end
            ST_DATA: begin
                if (cancel_s) begin
                    state_s = ST_IDLE;
                end else if (last_beat_s) begin
                    state_s = ST_FOOT;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_FOOT: begin
                if (tx_idle_i) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_FOOT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Winner capture, pointer advance and inter-frame gap countdown.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sel_r <= '0;
            len_r <= '0;
            ptr_r <= '0;
            gap_r <= '0;
        end else begin
            if (arb_go_s) begin
                sel_r <= win_s;
                len_r <= win_len_s;
            end else begin
                sel_r <= sel_r;
                len_r <= len_r;
            end
            if (cancel_s || frame_end_s) begin
                ptr_r <= next_ptr_s;
                gap_r <= IFG_W'(IFG_CYC);
            end else if (gap_r != '0) begin
                ptr_r <= ptr_r;
                gap_r <= gap_r - IFG_W'(1);
            end else begin
                ptr_r <= ptr_r;
                gap_r <= gap_r;
            end
        end
    end

    assign grant_o      = grant_s;
    assign sel_o        = sel_r;
    assign tx_early_v_o = early_v_s;
    assign tx_pkt_len_o = len_r;
    assign tx_cancel_o  = cancel_s;
    assign err_o        = cancel_s;
    assign busy_o       = (state_r != ST_IDLE) || (gap_r != '0);

endmodule
